// File: rtl/sseg_display_arbiter.sv
// Two-requester arbiter for a 4-digit seven-segment display with
// frame-coherent snapshots, inter-digit blanking and registered scan outputs.
module sseg_display_arbiter #(
  parameter int SCAN_DIV     = 50_000,
  parameter int BLANK_CYC    = 500,
  parameter int HOLD_FRAMES  = 250,
  parameter int B_MAX_FRAMES = 2000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_a_i,
  input  logic [15:0] data_a_i,
  input  logic        req_b_i,
  input  logic [15:0] data_b_i,
  output logic        gnt_a_o,
  output logic        gnt_b_o,
  output logic [6:0]  ld_o,
  output logic [3:0]  an_o
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(HOLD_FRAMES + 1);
  localparam int BW = $clog2(B_MAX_FRAMES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYC);
  localparam logic [AW-1:0] A_MAX     = AW'(HOLD_FRAMES);
  localparam logic [BW-1:0] B_MAX     = BW'(B_MAX_FRAMES);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [AW-1:0] a_frames_q, a_frames_d, a_inc;
  logic [BW-1:0] b_frames_q, b_frames_d, b_inc;
  logic [15:0]   shadow_q, shadow_d;
  logic          gnt_a_q, gnt_b_q;
  logic [6:0]    ld_q, ld_d;
  logic [3:0]    an_q, an_d;
  logic          fb;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign fb = (digit_q == 2'd3) && (scan_cnt_q == SCAN_LAST);

  // Counts include the frame closing at this FB, so HOLD_FRAMES / B_MAX_FRAMES
  // are the number of whole frames owned before a switch can happen.
  assign a_inc = (a_frames_q >= A_MAX) ? A_MAX : a_frames_q + 1'b1;
  assign b_inc = !req_a_i ? b_frames_q :
                 (b_frames_q >= B_MAX) ? B_MAX : b_frames_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    a_frames_d = a_frames_q;
    b_frames_d = b_frames_q;
    shadow_d   = shadow_q;
    scan_cnt_d = scan_cnt_q + 1'b1;
    digit_d    = digit_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      digit_d    = digit_q + 2'd1;
    end
    if (fb) begin
      case (state_q)
        IDLE: begin
          if (req_b_i)      state_d = OWN_B;
          else if (req_a_i) state_d = OWN_A;
        end
        OWN_A: begin
          if (req_b_i && a_inc >= A_MAX) state_d = OWN_B;
          else if (!req_a_i)             state_d = req_b_i ? OWN_B : IDLE;
        end
        OWN_B: begin
          if (!req_b_i)                       state_d = req_a_i ? OWN_A : IDLE;
          else if (req_a_i && b_inc >= B_MAX) state_d = OWN_A;
        end
        default: state_d = IDLE;
      endcase
      a_frames_d = (state_q == OWN_A && state_d == OWN_A) ? a_inc : '0;
      b_frames_d = (state_q == OWN_B && state_d == OWN_B) ? b_inc : '0;
      case (state_d)
        OWN_A:   shadow_d = data_a_i;
        OWN_B:   shadow_d = data_b_i;
        default: shadow_d = 16'hFFFF;
      endcase
    end
  end

  always_comb begin
    ld_d = seg7(shadow_q[{digit_q, 2'b00} +: 4]);
    an_d = 4'b1111;
    if (scan_cnt_q >= BLANK_END && state_q != IDLE)
      an_d = ~(4'b0001 << digit_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      scan_cnt_q <= '0;
      digit_q    <= 2'd0;
      a_frames_q <= '0;
      b_frames_q <= '0;
      shadow_q   <= 16'hFFFF;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      ld_q       <= 7'b1111111;
      an_q       <= 4'b1111;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      a_frames_q <= a_frames_d;
      b_frames_q <= b_frames_d;
      shadow_q   <= shadow_d;
      gnt_a_q    <= (state_d == OWN_A);
      gnt_b_q    <= (state_d == OWN_B);
      ld_q       <= ld_d;
      an_q       <= an_d;
    end
  end

  assign gnt_a_o = gnt_a_q;
  assign gnt_b_o = gnt_b_q;
  assign ld_o    = ld_q;
  assign an_o    = an_q;

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Directed bench: SCAN_DIV=4, BLANK_CYC=1, HOLD_FRAMES=2, B_MAX_FRAMES=3;
// a frame is 16 cycles, FB is cycle 15 mod 16 counted from the reset edge.
module tb_sseg_display_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [15:0] data_a = 16'h0, data_b = 16'h0;
  logic        gnt_a, gnt_b;
  logic [6:0]  ld;
  logic [3:0]  an;
  int          n_cmp = 0, n_bad = 0, cyc = 0;

  always #5 clk = ~clk;

  sseg_display_arbiter #(
    .SCAN_DIV(4), .BLANK_CYC(1), .HOLD_FRAMES(2), .B_MAX_FRAMES(3)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_a_i(req_a), .data_a_i(data_a),
    .req_b_i(req_b), .data_b_i(data_b),
    .gnt_a_o(gnt_a), .gnt_b_o(gnt_b),
    .ld_o(ld), .an_o(an)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic ea, input logic eb);
    chk({tag, ".gnt_a"}, 16'(gnt_a), 16'(ea));
    chk({tag, ".gnt_b"}, 16'(gnt_b), 16'(eb));
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] ea, input logic [6:0] el);
    chk({tag, ".an"}, 16'(an), 16'(ea));
    chk({tag, ".ld"}, 16'(ld), 16'(el));
  endtask

  // Advance k posedges, then settle at the following negedge.
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    @(negedge clk);
    cyc += k;
  endtask

  task automatic to(input int n);
    if (n > cyc) step(n - cyc);
  endtask

  // The reset edge becomes cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // T1: idle after reset for 5 frames
    do_reset();
    chk_gnt("rst", 1'b0, 1'b0);
    chk_disp("rst", 4'hF, 7'h7F);
    to(16); chk_gnt("idle16", 1'b0, 1'b0); chk_disp("idle16", 4'hF, 7'h7F);
    to(42); chk_disp("idle42", 4'hF, 7'h7F);
    to(80); chk_gnt("idle80", 1'b0, 1'b0); chk_disp("idle80", 4'hF, 7'h7F);

    // T2: A alone, 0255
    do_reset();
    req_a = 1'b1; data_a = 16'h0255;
    to(15); chk_gnt("a_pre", 1'b0, 1'b0);
    to(16); chk_gnt("a_gnt", 1'b1, 1'b0);
    to(17); chk("a_blank0", 16'(an), 16'hF);
    to(18); chk_disp("a_d0", 4'hE, 7'h12);
    to(21); chk("a_blank1", 16'(an), 16'hF);
    to(22); chk_disp("a_d1", 4'hD, 7'h12);
    to(26); chk_disp("a_d2", 4'hB, 7'h24);
    to(30); chk_disp("a_d3", 4'h7, 7'h40);

    // mid-slot reset
    to(34);
    do_reset();
    chk_gnt("midrst", 1'b0, 1'b0);
    chk_disp("midrst", 4'hF, 7'h7F);

    // T3: B preempts A only after HOLD_FRAMES frames; snapshot coherence
    to(16); chk_gnt("t3_a", 1'b1, 1'b0);
    req_b = 1'b1; data_b = 16'h1234;
    to(32); chk_gnt("t3_hold1", 1'b1, 1'b0);
    to(47); chk_gnt("t3_hold2", 1'b1, 1'b0);
    to(48); chk_gnt("t3_b", 1'b0, 1'b1);
    to(50); chk_disp("t3_b_d0", 4'hE, 7'h19);
    data_b = 16'h5678;
    to(54); chk_disp("t3_old_d1", 4'hD, 7'h30);
    to(66); chk_disp("t3_new_d0", 4'hE, 7'h00);

    // T4: simultaneous requests, forced fairness switch
    req_a = 1'b0; req_b = 1'b0;
    do_reset();
    req_a = 1'b1; req_b = 1'b1; data_a = 16'h0255; data_b = 16'h1234;
    to(15); chk_gnt("t4_pre", 1'b0, 1'b0);
    to(16); chk_gnt("t4_b", 1'b0, 1'b1);
    to(63); chk_gnt("t4_b3", 1'b0, 1'b1);
    to(64); chk_gnt("t4_forced_a", 1'b1, 1'b0);
    to(66); chk_disp("t4_a_d0", 4'hE, 7'h12);
    to(95); chk_gnt("t4_a2", 1'b1, 1'b0);
    to(96); chk_gnt("t4_b_again", 1'b0, 1'b1);

    // T5: B releases to IDLE, then A with non-BCD nibbles
    to(100); req_a = 1'b0; req_b = 1'b0;
    to(111); chk_gnt("t5_b", 1'b0, 1'b1);
    to(112); chk_gnt("t5_idle", 1'b0, 1'b0);
    req_a = 1'b1; data_a = 16'h00AB;
    to(114); chk_disp("t5_idle_d0", 4'hF, 7'h7F);
    to(118); chk_disp("t5_idle_d1", 4'hF, 7'h7F);
    to(127); chk_gnt("t5_pre_a", 1'b0, 1'b0);
    to(128); chk_gnt("t5_a", 1'b1, 1'b0);
    to(130); chk_disp("t5_B", 4'hE, 7'h7F);
    to(134); chk_disp("t5_A", 4'hD, 7'h7F);
    to(138); chk_disp("t5_0a", 4'hB, 7'h40);
    to(142); chk_disp("t5_0b", 4'h7, 7'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
